// File: rtl/eq_band_mixer.sv
// eq_band_mixer: weights NUM_BANDS filtered band samples by programmable
// Q2.10 gains and sums them with a single time-shared multiplier, producing
// one rounded, saturated sample per accepted enable strobe.
// Optional feature macro: MIX_CLIP_FLAG_EN (adds clip_clr input and a sticky
// clip_flag output that records saturation events).
module eq_band_mixer #(
  parameter int unsigned NUM_BANDS = 5,
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned GAIN_W    = 12,
  parameter int unsigned GAIN_FRAC = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [NUM_BANDS*DATA_W-1:0]   band_in,
  input  logic                          gain_wr_en,
  input  logic [$clog2(NUM_BANDS)-1:0]  gain_wr_addr,
  input  logic [GAIN_W-1:0]             gain_wr_data,
`ifdef MIX_CLIP_FLAG_EN
  input  logic                          clip_clr,
  output logic                          clip_flag,
`endif
  output logic [DATA_W-1:0]             audio_out,
  output logic                          out_valid,
  output logic                          busy
);

  localparam int unsigned ADDR_W = $clog2(NUM_BANDS);
  localparam int unsigned PROD_W = DATA_W + GAIN_W;
  localparam int unsigned ACC_W  = PROD_W + $clog2(NUM_BANDS);

  localparam logic [GAIN_W-1:0]       GAIN_UNITY = GAIN_W'(64'd1 << GAIN_FRAC);
  localparam logic [ADDR_W-1:0]       LAST_BAND  = ADDR_W'(NUM_BANDS - 1);
  localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(64'd1 << (GAIN_FRAC - 1));
  localparam logic signed [ACC_W-1:0] SAT_MAX    = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN    = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_MAC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_d;

  logic signed [DATA_W-1:0] band_snap [NUM_BANDS];
  logic signed [GAIN_W-1:0] gain_snap [NUM_BANDS];
  logic signed [GAIN_W-1:0] gain_reg  [NUM_BANDS];
  logic signed [ACC_W-1:0]  acc;
  logic [ADDR_W-1:0]        k;

  logic signed [PROD_W-1:0] product_c;
  logic signed [ACC_W-1:0]  rounded_c;
  logic signed [ACC_W-1:0]  shifted_c;
  logic                     sat_hi_c;
  logic                     sat_lo_c;
  logic [DATA_W-1:0]        sat_c;

  logic              busy_d;
  logic              valid_d;
  logic [DATA_W-1:0] audio_d;

  // One band product per MAC cycle, operands sign-extended to full product width
  assign product_c = PROD_W'(band_snap[k]) * PROD_W'(gain_snap[k]);

  // Round half up, drop the gain fraction, then clamp to the output range
  always_comb begin
    rounded_c = acc + ROUND_HALF;
    shifted_c = rounded_c >>> GAIN_FRAC;
    sat_hi_c  = (shifted_c > SAT_MAX);
    sat_lo_c  = (shifted_c < SAT_MIN);
    if (sat_hi_c) begin
      sat_c = SAT_MAX[DATA_W-1:0];
    end else if (sat_lo_c) begin
      sat_c = SAT_MIN[DATA_W-1:0];
    end else begin
      sat_c = shifted_c[DATA_W-1:0];
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_d = state;
    valid_d = 1'b0;
    audio_d = audio_out;
    unique case (state)
      S_IDLE: if (enable) state_d = S_LOAD;
      S_LOAD: state_d = S_MAC;
      S_MAC:  if (k == LAST_BAND) state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        valid_d = 1'b1;
        audio_d = sat_c;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      audio_out <= '0;
    end else begin
      state     <= state_d;
      busy      <= busy_d;
      out_valid <= valid_d;
      audio_out <= audio_d;
    end
  end

  // Snapshot in LOAD, accumulate one band per MAC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      k   <= '0;
      for (int unsigned i = 0; i < NUM_BANDS; i++) begin
        band_snap[i] <= '0;
        gain_snap[i] <= '0;
      end
    end else begin
      unique case (state)
        S_LOAD: begin
          acc <= '0;
          k   <= '0;
          for (int unsigned i = 0; i < NUM_BANDS; i++) begin
            band_snap[i] <= band_in[i*DATA_W +: DATA_W];
            gain_snap[i] <= gain_reg[i];
          end
        end
        S_MAC: begin
          acc <= acc + ACC_W'(product_c);
          if (k != LAST_BAND) k <= k + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Gain register file; out-of-range addresses are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_BANDS; i++) begin
        gain_reg[i] <= GAIN_UNITY;
      end
    end else if (gain_wr_en && (32'(gain_wr_addr) < NUM_BANDS)) begin
      gain_reg[gain_wr_addr] <= gain_wr_data;
    end
  end

`ifdef MIX_CLIP_FLAG_EN
  logic clip_d;

  // Sticky clip flag: a new clip wins over a simultaneous clear
  always_comb begin
    clip_d = clip_flag & ~clip_clr;
    if ((state == S_DONE) && (sat_hi_c || sat_lo_c)) clip_d = 1'b1;
  end

  // Clip flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_flag <= 1'b0;
    end else begin
      clip_flag <= clip_d;
    end
  end
`endif

endmodule
